// File: rtl/regfile_tagged_pkg.sv
// Shared definitions for the tagged architectural register file.
//   XLEN_DEF / AW_DEF / TAGW_DEF : default data, address and ROB-tag widths
//   REG_ZERO                     : address of the hardwired-zero register x0
//   ZERO_WORD                    : all-zero data word returned for x0 and in reset
//   rf_entry_t                   : per-register rename entry {busy, tag} at the
//                                  default tag width
package regfile_tagged_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int TAGW_DEF = 4;

  localparam logic [AW_DEF-1:0]   REG_ZERO  = '0;
  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic                busy;
    logic [TAGW_DEF-1:0] tag;
  } rf_entry_t;

endpackage

// File: rtl/regfile_tagged_rdport.sv
// One combinational read port of the tagged register file.
// Applies, in order: reset forcing, x0 zeroing, commit bypass of data, and
// clearing of busy/tag when the retiring instruction is the current producer.
// Ports:
//   rst_i            active-low reset; outputs forced to zero while low
//   addr_i           source register address
//   commit_*_i       this cycle's ROB retirement (enable, address, tag, data)
//   st_data_i/st_busy_i/st_tag_i  stored state of the addressed register
//   data_o/busy_o/tag_o           operand value, pending flag and producer tag
module regfile_tagged_rdport
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            rst_i,
  input  logic [AW-1:0]   addr_i,
  input  logic            commit_en_i,
  input  logic [AW-1:0]   commit_addr_i,
  input  logic [TAGW-1:0] commit_tag_i,
  input  logic [XLEN-1:0] commit_data_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic            st_busy_i,
  input  logic [TAGW-1:0] st_tag_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o,
  output logic [TAGW-1:0] tag_o
);

  always_comb begin
    data_o = XLEN'(ZERO_WORD);
    busy_o = 1'b0;
    tag_o  = '0;
    if (rst_i && (addr_i != AW'(REG_ZERO))) begin
      data_o = st_data_i;
      busy_o = st_busy_i;
      tag_o  = st_tag_i;
      if (commit_en_i && (commit_addr_i == addr_i)) begin
        data_o = commit_data_i;
        // Only the matching producer resolves the operand; a younger rename
        // of the same register keeps it pending.
        if (st_busy_i && (st_tag_i == commit_tag_i)) begin
          busy_o = 1'b0;
          tag_o  = '0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and producer ROB tag.
// Reads are combinational and see this cycle's commit but not this cycle's
// rename. Rename, commit and flush update state at the clock edge.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   flush                    mispredict flush: clears busy/tag, keeps data
//   rename_en/addr/tag       allocate a new producer for a destination
//   commit_en/addr/tag/data  ROB retirement
//   rd_addr                  NRD packed read addresses
//   rd_data/rd_busy/rd_tag   NRD packed read results
//   busy_cnt                 registered population count of busy bits
module regfile_tagged
  import regfile_tagged_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int AW   = AW_DEF,
  parameter int NRD  = 2,
  parameter int TAGW = TAGW_DEF,
  parameter int CW   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rename_en,
  input  logic [AW-1:0]     rename_addr,
  input  logic [TAGW-1:0]   rename_tag,
  input  logic              commit_en,
  input  logic [AW-1:0]     commit_addr,
  input  logic [TAGW-1:0]   commit_tag,
  input  logic [XLEN-1:0]   commit_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic [NRD*TAGW-1:0] rd_tag,
  output logic [CW-1:0]       busy_cnt
);

  logic [XLEN-1:0] data_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [TAGW-1:0] tag_q  [NREG];
  logic [TAGW-1:0] tag_d  [NREG];
  logic [CW-1:0]   cnt_q, cnt_d;

  // Writable address: not x0 and inside the implemented register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != AW'(REG_ZERO)) && (int'(a) < NREG);
  endfunction

  logic ren_ok, cm_ok, cm_clr, ren_new;

  always_comb begin
    ren_ok  = rename_en && addr_ok(rename_addr) && !flush;
    cm_ok   = commit_en && addr_ok(commit_addr);
    // A same-cycle rename of the committing register keeps it busy.
    cm_clr  = cm_ok && busy_q[commit_addr] && (tag_q[commit_addr] == commit_tag)
              && !(ren_ok && (rename_addr == commit_addr));
    ren_new = ren_ok && !busy_q[rename_addr];
  end

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (flush) begin
      busy_d = '0;
      for (int r = 0; r < NREG; r++) tag_d[r] = '0;
      cnt_d  = '0;
    end else begin
      if (cm_clr) begin
        busy_d[commit_addr] = 1'b0;
        tag_d[commit_addr]  = '0;
      end
      if (ren_ok) begin
        busy_d[rename_addr] = 1'b1;
        tag_d[rename_addr]  = rename_tag;
      end
      // Net zero when one bit is set and another cleared in the same cycle.
      if (ren_new && !cm_clr) begin
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
      end else if (cm_clr && !ren_new) begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Committed data survives a flush: the ROB head is older than the flush.
      if (cm_ok) data_q[commit_addr] <= commit_data;
      for (int r = 0; r < NREG; r++) tag_q[r] <= tag_d[r];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] sd;
    logic            sb;
    logic [TAGW-1:0] st;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      sd = '0;
      sb = 1'b0;
      st = '0;
      if (int'(a) < NREG) begin
        sd = data_q[a];
        sb = busy_q[a];
        st = tag_q[a];
      end
    end

    regfile_tagged_rdport #(
      .XLEN (XLEN),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_rdport (
      .rst_i         (rst),
      .addr_i        (a),
      .commit_en_i   (commit_en),
      .commit_addr_i (commit_addr),
      .commit_tag_i  (commit_tag),
      .commit_data_i (commit_data),
      .st_data_i     (sd),
      .st_busy_i     (sb),
      .st_tag_i      (st),
      .data_o        (rd_data[i*XLEN +: XLEN]),
      .busy_o        (rd_busy[i]),
      .tag_o         (rd_tag[i*TAGW +: TAGW])
    );
  end

endmodule

// File: tb/tb_regfile_tagged.sv
module tb_regfile_tagged;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int TAGW = 4;
  localparam int CW   = 6;
  localparam int W    = 2 + XLEN + 1 + TAGW;

  logic                clk;
  logic                rst;
  logic                flush;
  logic                rename_en;
  logic [AW-1:0]       rename_addr;
  logic [TAGW-1:0]     rename_tag;
  logic                commit_en;
  logic [AW-1:0]       commit_addr;
  logic [TAGW-1:0]     commit_tag;
  logic [XLEN-1:0]     commit_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NRD*TAGW-1:0] rd_tag;
  logic [CW-1:0]       busy_cnt;

  regfile_tagged #(
    .XLEN (XLEN), .NREG (NREG), .AW (AW), .NRD (NRD), .TAGW (TAGW), .CW (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rename_en   (rename_en),
    .rename_addr (rename_addr),
    .rename_tag  (rename_tag),
    .commit_en   (commit_en),
    .commit_addr (commit_addr),
    .commit_tag  (commit_tag),
    .commit_data (commit_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .rd_tag      (rd_tag),
    .busy_cnt    (busy_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: {port, data, busy, tag}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [1:0]      ep;
  logic [XLEN-1:0] ed, ad;
  logic            eb, ab;
  logic [TAGW-1:0] et, at;

  // reference model for the random phase
  logic [XLEN-1:0] m_data [NREG];
  logic            m_busy [NREG];
  logic [TAGW-1:0] m_tag  [NREG];

  // driver tasks
  task automatic clear_inputs();
    flush = 1'b0;
    rename_en = 1'b0; rename_addr = '0; rename_tag = '0;
    commit_en = 1'b0; commit_addr = '0; commit_tag = '0; commit_data = '0;
  endtask

  task automatic do_rename(input logic [AW-1:0] a, input logic [TAGW-1:0] t);
    rename_en = 1'b1; rename_addr = a; rename_tag = t;
  endtask

  task automatic do_commit(input logic [AW-1:0] a, input logic [TAGW-1:0] t,
                           input logic [XLEN-1:0] d);
    commit_en = 1'b1; commit_addr = a; commit_tag = t; commit_data = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic push_exp(input logic [1:0] p, input logic [XLEN-1:0] d,
                          input logic b, input logic [TAGW-1:0] t);
    exp_q.push_back({p, d, b, t});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    set_rd(0, 5); set_rd(1, 0);
    tick(); tick();
    total++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h busy=%b tag=%h want all zero", rd_data, rd_busy, rd_tag);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    push_exp(0, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL reset_read p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
  endtask

  task automatic test_commit_read();
    do_commit(5, 3, 32'hDEADBEEF);
    set_rd(0, 5); set_rd(1, 6);
    #1;
    push_exp(0, 32'hDEADBEEF, 1'b0, 4'h0);
    push_exp(1, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL commit_bypass p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    push_exp(0, 32'hDEADBEEF, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL commit_stored p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL commit_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_rename_commit();
    do_rename(7, 9);
    set_rd(0, 7); set_rd(1, 5);
    #1;
    // same-cycle rename is not yet visible
    push_exp(0, 32'h0, 1'b0, 4'h0);
    push_exp(1, 32'hDEADBEEF, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL rename_old_map p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    push_exp(0, 32'h0, 1'b1, 4'd9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL rename_busy p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rename_cnt: got %0d want 1", busy_cnt); end
    do_commit(7, 9, 32'h11);
    #1;
    push_exp(0, 32'h11, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et) || (!eb && at !== et)) begin bad++;
        $display("FAIL commit_resolve p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL commit_resolve_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_younger_producer();
    do_rename(7, 2); tick();
    do_rename(7, 4); tick();
    clear_inputs(); #1;
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rerename_cnt: got %0d want 1", busy_cnt); end
    do_commit(7, 2, 32'h22);
    #1;
    push_exp(0, 32'h22, 1'b1, 4'd4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL stale_bypass p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    push_exp(0, 32'h22, 1'b1, 4'd4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL stale_stored p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL stale_cnt: got %0d want 1", busy_cnt); end
    do_commit(7, 4, 32'h23); tick(); clear_inputs(); #1;
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL young_commit_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_same_cycle();
    set_rd(0, 3);
    do_rename(3, 6); tick(); clear_inputs();
    do_rename(3, 6); do_commit(3, 6, 32'h33);
    #1;
    push_exp(0, 32'h33, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL same_cycle_bypass p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    push_exp(0, 32'h33, 1'b1, 4'd6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL same_cycle_stored p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL same_cycle_cnt: got %0d want 1", busy_cnt); end
    do_commit(3, 6, 32'h34); tick(); clear_inputs(); #1;
  endtask

  task automatic test_flush();
    do_rename(1, 1); tick();
    do_rename(2, 2); tick();
    do_rename(3, 3); tick();
    clear_inputs(); #1;
    total++;
    if (busy_cnt !== 6'd3) begin bad++; $display("FAIL pre_flush_cnt: got %0d want 3", busy_cnt); end
    flush = 1'b1;
    do_commit(1, 1, 32'h55);
    do_rename(4, 5);
    tick(); clear_inputs();
    set_rd(0, 1); set_rd(1, 4);
    #1;
    push_exp(0, 32'h55, 1'b0, 4'h0);
    push_exp(1, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL flush_x1_x4 p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (rd_tag !== '0) begin bad++; $display("FAIL flush_tags: got %h want 0", rd_tag); end
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    set_rd(0, 2); set_rd(1, 3);
    #1;
    push_exp(0, 32'h0, 1'b0, 4'h0);
    push_exp(1, 32'h34, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL flush_x2_x3 p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
  endtask

  task automatic test_x0();
    do_rename(0, 7);
    do_commit(0, 7, 32'hFFFF_FFFF);
    set_rd(0, 0); set_rd(1, 0);
    #1;
    push_exp(0, 32'h0, 1'b0, 4'h0);
    push_exp(1, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || at !== et) begin bad++;
        $display("FAIL x0_comb p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    tick(); clear_inputs(); #1;
    push_exp(0, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || at !== et) begin bad++;
        $display("FAIL x0_stored p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_back_to_back();
    logic            ren, cen, fl;
    logic [AW-1:0]   ra, ca, a;
    logic [TAGW-1:0] rt, ct;
    logic [XLEN-1:0] cd, d;
    logic            b, rok, clr;
    logic [TAGW-1:0] t;
    int              pop;
    rst = 1'b0; clear_inputs(); tick(); rst = 1'b1;
    for (int r = 0; r < NREG; r++) begin m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      ren = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 7));
      rt  = TAGW'($urandom_range(0, 15));
      cen = 1'($urandom_range(0, 1));
      ca  = AW'($urandom_range(0, 7));
      ct  = ($urandom_range(0, 3) != 0) ? m_tag[ca] : TAGW'($urandom_range(0, 15));
      cd  = $urandom;
      fl  = ($urandom_range(0, 19) == 0);
      flush = fl;
      rename_en = ren; rename_addr = ra; rename_tag = rt;
      commit_en = cen; commit_addr = ca; commit_tag = ct; commit_data = cd;
      for (int p = 0; p < NRD; p++) begin
        a = AW'($urandom_range(0, 7));
        set_rd(p, a);
        d = '0; b = 1'b0; t = '0;
        if (a != 0) begin
          d = m_data[a]; b = m_busy[a]; t = m_tag[a];
          if (cen && ca == a) begin
            d = cd;
            if (b && t == ct) begin b = 1'b0; t = '0; end
          end
        end
        push_exp(2'(p), d, b, t);
      end
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); {ep, ed, eb, et} = e;
        ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
        total++;
        if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
          $display("FAIL random_read c%0d p%0d: got %h/%b/%h want %h/%b/%h", cyc, ep, ad, ab, at, ed, eb, et); end
      end
      // model update from the architectural rules
      rok = ren && ra != 0;
      clr = cen && ca != 0 && m_busy[ca] && m_tag[ca] == ct && !(rok && ra == ca);
      if (cen && ca != 0) m_data[ca] = cd;
      if (fl) begin
        for (int r = 0; r < NREG; r++) begin m_busy[r] = 1'b0; m_tag[r] = '0; end
      end else begin
        if (clr) m_busy[ca] = 1'b0;
        if (rok) begin m_busy[ra] = 1'b1; m_tag[ra] = rt; end
      end
      tick();
      pop = 0;
      for (int r = 0; r < NREG; r++) pop += int'(m_busy[r]);
      total++;
      if (busy_cnt !== CW'(pop)) begin bad++;
        $display("FAIL random_cnt c%0d: got %0d want %0d", cyc, busy_cnt, pop); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_rename(9, 3); tick(); clear_inputs();
    do_commit(10, 1, 32'hAB); tick(); clear_inputs();
    rst = 1'b0;
    do_rename(11, 2);
    set_rd(0, 10); set_rd(1, 9);
    #1;
    total++;
    if (rd_data !== '0 || rd_busy !== '0 || rd_tag !== '0) begin
      bad++;
      $display("FAIL reset_forced: got data=%h busy=%b tag=%h want all zero", rd_data, rd_busy, rd_tag);
    end
    tick(); rst = 1'b1; clear_inputs(); #1;
    push_exp(0, 32'h0, 1'b0, 4'h0);
    push_exp(1, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL reset_cleared p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_mid_cnt: got %0d want 0", busy_cnt); end
    set_rd(0, 11);
    #1;
    push_exp(0, 32'h0, 1'b0, 4'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); {ep, ed, eb, et} = e;
      ad = rd_data[ep*XLEN +: XLEN]; ab = rd_busy[ep]; at = rd_tag[ep*TAGW +: TAGW];
      total++;
      if (ad !== ed || ab !== eb || (eb && at !== et)) begin bad++;
        $display("FAIL reset_drops_rename p%0d: got %h/%b/%h want %h/%b/%h", ep, ad, ab, at, ed, eb, et); end
    end
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    clear_inputs();
    test_reset();
    test_commit_read();
    test_rename_commit();
    test_younger_producer();
    test_same_cycle();
    test_flush();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
